// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package uart_pkg;

  localparam int UART_FRAME_BITS      = 10;
  localparam int CLKS_PER_BIT_DEFAULT = 868;
  localparam int UART_DATA_W          = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: free-running 0..CLKS_PER_BIT-1, restartable by clear.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_param
      $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_done = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the upstream FIFO and sends each as a UART 8N1 frame, LSB first.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [15:0]       bytes_sent,
  output tx_state_t         state_dbg
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_t         state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [IDX_W-1:0]  bit_idx, bit_idx_n;
  logic [15:0]       bytes_sent_n;
  logic              tx_d, busy_d, rd_en_d;
  logic              bit_done, baud_clear;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      bytes_sent <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_idx    <= bit_idx_n;
      bytes_sent <= bytes_sent_n;
      tx         <= tx_d;
      busy       <= busy_d;
      fifo_rd_en <= rd_en_d;
    end
  end

  // Outputs are registered by computing them from the next state.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_idx_n    = bit_idx;
    bytes_sent_n = bytes_sent;
    baud_clear   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_en && !fifo_empty) state_n = FETCH;
      end
      FETCH: begin
        state_n = LOAD;
      end
      LOAD: begin
        shreg_n    = fifo_data;
        bit_idx_n  = '0;
        baud_clear = 1'b1;
        state_n    = START;
      end
      START: begin
        if (bit_done) state_n = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shreg_n   = shreg >> 1;
          bit_idx_n = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) state_n = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          bytes_sent_n = bytes_sent + 16'd1;
          state_n      = (tx_en && !fifo_empty) ? FETCH : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    rd_en_d = (state_n == FETCH);
    busy_d  = (state_n != IDLE);
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_n[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Downstream consumer of the 8-bit, 64-deep `Fifo` buffer. It pops bytes whenever the FIFO is non-empty and transmission is enabled, and serializes each byte as a UART 8N1 frame (LSB first) on a single line. It provides the FIFO's `rd_en` and consumes `buf_out` and `buf_empty`. It adds a frame counter for software visibility.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `DATA_W`, 8: byte width; fixed at 8, matches FIFO `buf_in`/`buf_out`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_en`  in  1  permit starting new frames; sampled only in IDLE and at end of STOP.
- `fifo_empty`  in  1  from FIFO `buf_empty`.
- `fifo_data`  in  8  from FIFO `buf_out`; valid the cycle after `fifo_rd_en` is high.
- `fifo_rd_en`  out  1  to FIFO `rd_en`; single-cycle pop pulse.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high from FETCH through the last STOP cycle.
- `bytes_sent`  out  16  count of completed frames.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: if `tx_en && !fifo_empty` go to FETCH, otherwise stay.
- FETCH (1 cycle): `fifo_rd_en`=1. This is the only state that drives it high.
- LOAD (1 cycle): capture `fifo_data` into the 8-bit shift register, clear the baud counter and the bit index.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=shreg[0]. Every CLKS_PER_BIT cycles shift right and increment the bit index (3 bits). After bit 7's period, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, `bytes_sent` += 1 (wraps 0xFFFF→0x0000). Then:
  - if `tx_en && !fifo_empty` go directly to FETCH;
  - else go to IDLE.
- `tx_en` falling mid-frame: the current frame completes normally and no new frame starts.
- `fifo_empty` is never sampled outside IDLE and end of STOP. The block is the FIFO's only reader, so data is guaranteed after a non-empty sample.
- Baud counter width: $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and rolls over at each bit boundary.

## Timing
- Reset values (asynchronous): state=IDLE, `tx`=1, `busy`=0, `fifo_rd_en`=0, `bytes_sent`=0, shreg=0, counters=0.
- Reset mid-frame: `tx` returns to 1 immediately. The in-flight byte is lost and `bytes_sent` is not incremented.
- All outputs are registered.
- Latency: `!fifo_empty` sampled at edge k → `fifo_rd_en` high in cycle k+1 → LOAD in k+2 → `tx` low from k+3.
- Frame length: 10×CLKS_PER_BIT cycles of START+DATA+STOP.
- Back-to-back frames: inter-frame gap is exactly 2 idle-high cycles (FETCH+LOAD) beyond the stop bit.
- `busy` rises with FETCH and falls on the cycle the state returns to IDLE. It stays high continuously across back-to-back frames.

## Structure
- Package `uart_pkg` holds:
  - state enum `tx_state_t`;
  - constant `UART_FRAME_BITS`=10;
  - default `CLKS_PER_BIT`=868.
- One natural sub-module, `uart_baud_gen`: the parameterized bit-period counter. Inputs are `clk`, `rst` and a `clear` strobe (pulsed in LOAD); output is a `bit_done` pulse at count CLKS_PER_BIT-1.

## Test plan
Run with CLKS_PER_BIT=4, so a frame is 40 cycles.
- **Reset:** `rst`=1 for 2 cycles → `tx`=1, `busy`=0, `fifo_rd_en`=0, `bytes_sent`=0.
- **Single byte 0xA5:** one FIFO write, `tx_en`=1 → exactly one `fifo_rd_en` pulse. `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `bytes_sent`=1 and the FIFO is empty afterwards.
- **Back-to-back:** write 0x00,0xFF,0x55 → three frames decode correctly. Each gap is exactly 2 idle cycles, `busy` stays high throughout, and `bytes_sent`=3.
- **Full drain:** write 64 bytes 0..63 until FIFO `buf_full`=1 → 64 frames decode to 0..63 in order. `fifo_empty`=1 at the end and `bytes_sent`=64.
- **`tx_en` gating:** deassert `tx_en` mid-frame 2 of 3 queued bytes → frame 2 completes and frame 3 does not start, with `fifo_counter`=1. Reasserting `tx_en` sends byte 3.
- **Reset mid-frame:** assert `rst` during DATA bit 3 → `tx`=1 asynchronously and `bytes_sent`=0. After release, the remaining FIFO bytes are sent normally.
